// File: rtl/switch_bus_receiver.sv
// switch_bus_receiver: registered read side of a switch-gated shared bus.
// Resolves N_SRC gated sources each cycle, holds the last legal value,
// and flags/counts contention.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   src_en[N_SRC]        per-source switch enable
//   src_data[N_SRC*W]    source data, source i at [i*WIDTH +: WIDTH]
//   clr_err              sync clear of conflict / conflict_cnt
//   out_data             last resolved bus value (held)
//   out_valid            bus legally driven in previous sample
//   floating             no source enabled in previous sample
//   conflict             sticky contention flag
//   conflict_cnt         saturating contended-cycle count
//   capture_cnt          wrapping valid-capture count
//   state                0 FLOAT, 1 DRIVEN, 2 CONTENDED
module switch_bus_receiver #(
    parameter int N_SRC = 2,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       src_en,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic                   floating,
    output logic                   conflict,
    output logic [CNT_W-1:0]       conflict_cnt,
    output logic [CNT_W-1:0]       capture_cnt,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        ST_FLOAT   = 2'd0,
        ST_DRIVEN  = 2'd1,
        ST_CONT    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_float;
    logic               r_conflict;
    logic [CNT_W-1:0]   r_conflict_cnt;
    logic [CNT_W-1:0]   r_capture_cnt;

    logic               w_any;
    logic               w_diff;
    logic [WIDTH-1:0]   w_val;

    // The first enabled source sets the reference value; any later
    // enabled source that disagrees marks the sample as contended.
    always_comb begin
        w_any  = 1'b0;
        w_diff = 1'b0;
        w_val  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_en[i]) begin
                if (!w_any) begin
                    w_any = 1'b1;
                    w_val = src_data[i*WIDTH +: WIDTH];
                end else if (src_data[i*WIDTH +: WIDTH] != w_val) begin
                    w_diff = 1'b1;
                end
            end
        end
    end

    // Memoryless: next state depends only on the current sample.
    always_comb begin
        w_next = ST_FLOAT;
        if (w_any && w_diff) begin
            w_next = ST_CONT;
        end else if (w_any) begin
            w_next = ST_DRIVEN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FLOAT;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_float        <= 1'b1;
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
            r_capture_cnt  <= '0;
        end else begin
            r_valid <= (w_next == ST_DRIVEN);
            r_float <= (w_next == ST_FLOAT);
            if (w_next == ST_DRIVEN) begin
                r_data        <= w_val;
                r_capture_cnt <= r_capture_cnt + 1'b1;
            end
            // A contended cycle overrides a simultaneous clear.
            if (w_next == ST_CONT) begin
                r_conflict <= 1'b1;
                if (clr_err) begin
                    r_conflict_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (r_conflict_cnt != {CNT_W{1'b1}}) begin
                    r_conflict_cnt <= r_conflict_cnt + 1'b1;
                end
            end else if (clr_err) begin
                r_conflict     <= 1'b0;
                r_conflict_cnt <= '0;
            end
        end
    end

    assign out_data     = r_data;
    assign out_valid    = r_valid;
    assign floating     = r_float;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_conflict_cnt;
    assign capture_cnt  = r_capture_cnt;
    assign state        = r_state;

endmodule

// File: tb/tb_switch_bus_receiver.sv
// tb_switch_bus_receiver: directed bench for switch_bus_receiver.
// Two sources, 8-bit data, 8-bit counters.
module tb_switch_bus_receiver;

    logic        clk;
    logic        rst_n;
    logic [1:0]  src_en;
    logic [15:0] src_data;
    logic        clr_err;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        floating;
    logic        conflict;
    logic [7:0]  conflict_cnt;
    logic [7:0]  capture_cnt;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    switch_bus_receiver #(
        .N_SRC(2),
        .WIDTH(8),
        .CNT_W(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_en      (src_en),
        .src_data    (src_data),
        .clr_err     (clr_err),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .floating    (floating),
        .conflict    (conflict),
        .conflict_cnt(conflict_cnt),
        .capture_cnt (capture_cnt),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; src_en = 2'b00; src_data = 16'h0; clr_err = 1'b0;
        #2 rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (out_data !== 8'h00) begin errors++;
            $display("FAIL reset_data got %h exp 00", out_data); end
        checks++; if (floating !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_flags got f=%b v=%b exp f=1 v=0", floating, out_valid); end
        checks++; if (state !== 2'd0) begin errors++;
            $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (conflict !== 1'b0 || conflict_cnt !== 8'd0 || capture_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnts got c=%b cc=%0d cap=%0d exp 0 0 0",
                     conflict, conflict_cnt, capture_cnt); end
    endtask

    task automatic test_single();
        src_en = 2'b01; src_data = 16'h005A;
        step();
        checks++; if (out_data !== 8'h5A || out_valid !== 1'b1 || state !== 2'd1) begin errors++;
            $display("FAIL single_drive got d=%h v=%b s=%0d exp 5a 1 1",
                     out_data, out_valid, state); end
        src_en = 2'b00; src_data = 16'hA5A5;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_data !== 8'h5A || floating !== 1'b1 || out_valid !== 1'b0 || state !== 2'd0) begin
                errors++;
                $display("FAIL single_hold got d=%h f=%b v=%b s=%0d exp 5a 1 0 0",
                         out_data, floating, out_valid, state); end
        end
        checks++; if (capture_cnt !== 8'd1) begin errors++;
            $display("FAIL single_cap got %0d exp 1", capture_cnt); end
    endtask

    task automatic test_contend();
        src_en = 2'b11; src_data = 16'h3C3C;
        step();
        checks++; if (state !== 2'd1 || out_data !== 8'h3C || conflict !== 1'b0) begin errors++;
            $display("FAIL equal_drive got s=%0d d=%h c=%b exp 1 3c 0",
                     state, out_data, conflict); end
        src_data = 16'hC33C;
        step();
        checks++; if (state !== 2'd2 || out_data !== 8'h3C || out_valid !== 1'b0 || floating !== 1'b0) begin
            errors++;
            $display("FAIL contend got s=%0d d=%h v=%b f=%b exp 2 3c 0 0",
                     state, out_data, out_valid, floating); end
        checks++; if (conflict !== 1'b1 || conflict_cnt !== 8'd1 || capture_cnt !== 8'd2) begin errors++;
            $display("FAIL contend_cnt got c=%b cc=%0d cap=%0d exp 1 1 2",
                     conflict, conflict_cnt, capture_cnt); end
    endtask

    task automatic test_disabled();
        src_en = 2'b10; src_data = 16'h11FF;
        step();
        checks++; if (out_data !== 8'h11 || state !== 2'd1 || conflict_cnt !== 8'd1) begin errors++;
            $display("FAIL disabled got d=%h s=%0d cc=%0d exp 11 1 1",
                     out_data, state, conflict_cnt); end
    endtask

    task automatic test_clear();
        src_en = 2'b11; src_data = 16'h1234;
        step(); step();
        checks++; if (conflict_cnt !== 8'd3) begin errors++;
            $display("FAIL clr_pre got %0d exp 3", conflict_cnt); end
        src_en = 2'b01; src_data = 16'h0077; clr_err = 1'b1;
        step();
        checks++; if (conflict !== 1'b0 || conflict_cnt !== 8'd0 || out_data !== 8'h77) begin errors++;
            $display("FAIL clr_plain got c=%b cc=%0d d=%h exp 0 0 77",
                     conflict, conflict_cnt, out_data); end
        src_en = 2'b11; src_data = 16'h0102; clr_err = 1'b1;
        step();
        checks++; if (conflict !== 1'b1 || conflict_cnt !== 8'd1) begin errors++;
            $display("FAIL clr_set_wins got c=%b cc=%0d exp 1 1", conflict, conflict_cnt); end
        clr_err = 1'b0;
    endtask

    task automatic test_transitions();
        src_en = 2'b00; step();
        checks++; if (state !== 2'd0) begin errors++;
            $display("FAIL cont_to_float got %0d exp 0", state); end
        src_en = 2'b11; src_data = 16'hAB00; step();
        checks++; if (state !== 2'd2 || out_data !== 8'h77) begin errors++;
            $display("FAIL float_to_cont got s=%0d d=%h exp 2 77", state, out_data); end
        src_en = 2'b10; step();
        checks++; if (state !== 2'd1 || out_data !== 8'hAB) begin errors++;
            $display("FAIL cont_to_drv got s=%0d d=%h exp 1 ab", state, out_data); end
    endtask

    task automatic test_saturate();
        src_en = 2'b11; src_data = 16'h55AA;
        for (int i = 0; i < 300; i++) step();
        checks++; if (conflict_cnt !== 8'd255 || out_data !== 8'hAB) begin errors++;
            $display("FAIL saturate got cc=%0d d=%h exp 255 ab", conflict_cnt, out_data); end
        step();
        checks++; if (conflict_cnt !== 8'd255) begin errors++;
            $display("FAIL saturate_hold got %0d exp 255", conflict_cnt); end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_data !== 8'h00 || floating !== 1'b1 || out_valid !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL async_rst got d=%h f=%b v=%b s=%0d exp 00 1 0 0",
                     out_data, floating, out_valid, state); end
        checks++; if (conflict !== 1'b0 || conflict_cnt !== 8'd0 || capture_cnt !== 8'd0) begin errors++;
            $display("FAIL async_rst_cnt got c=%b cc=%0d cap=%0d exp 0 0 0",
                     conflict, conflict_cnt, capture_cnt); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        src_en = 2'b01;
        for (int i = 0; i < 255; i++) begin
            src_data = 16'(i);
            step();
        end
        checks++; if (capture_cnt !== 8'd255 || out_data !== 8'hFE) begin errors++;
            $display("FAIL wrap_pre got cap=%0d d=%h exp 255 fe", capture_cnt, out_data); end
        src_data = 16'h00C0;
        step();
        checks++; if (capture_cnt !== 8'd0 || out_data !== 8'hC0) begin errors++;
            $display("FAIL wrap got cap=%0d d=%h exp 0 c0", capture_cnt, out_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contend();
        test_disabled();
        test_clear();
        test_transitions();
        test_saturate();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
